uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 asynchronous serial receiver that pairs with the team's uart_tx: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle-high line.
- Samples the serial input at mid-bit using a per-bit clock-cycle counter.
- Assembles each frame into a byte and presents it in a holding register with a ready/read handshake.
- Sits between the board RX pin and the consuming logic (command parser / FIFO).

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz / 9600 baud); must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2, counter value at which the start bit is re-checked.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line, idle high
- read  input  1  consumer acknowledge; pops the holding register when rxrdy=1
- data  output  8  received byte, stable while rxrdy=1
- rxrdy  output  1  holding register contains an unread byte
- frame_err  output  1  stop bit of the byte in data was sampled 0
- overrun  output  1  at least one byte was dropped because rxrdy was still set

Behaviour:
- Reset: data=0, rxrdy=0, frame_err=0, overrun=0, state=IDLE, counter=0, bit index=0, synchronizer flops=1.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only. Pin-to-rx_s latency is 2 cycles.
- Counter (13 bits): cleared on every state change, otherwise increments each cycle in START/DATA/STOP.
- IDLE: rx_s==0 -> START.
- START: at counter==HALF_BIT, sample rx_s.
  - 0 -> DATA, bit index=0.
  - 1 -> IDLE (glitch rejected, no status change).
- DATA: at counter==CLKS_PER_BIT-1, shift rx_s into shift register MSB (shift right), so bit 0 ends in the LSB. After the 8th sample -> STOP.
- STOP: at counter==CLKS_PER_BIT-1, sample rx_s and perform a byte load (below).
  - rx_s==1 -> IDLE.
  - rx_s==0 -> BREAK.
- BREAK: wait until rx_s==1, then -> IDLE. Prevents a held-low line from retriggering frames.
- Byte load (one cycle, the cycle after the stop sample):
  - If rxrdy==0, or read==1 in the same cycle: data<=shift register, frame_err<=~stop sample, rxrdy<=1.
  - Otherwise (rxrdy==1, no read): byte discarded; data and frame_err unchanged; overrun<=1.
- read with rxrdy==1 and no byte load in the same cycle: rxrdy<=0, overrun<=0. frame_err is held until the next load. read with rxrdy==0 is ignored.
- Simultaneous read + byte load: the new byte is loaded, rxrdy stays 1, overrun<=0.
- Latency from rx falling edge to rxrdy=1: 2 + 1 + (HALF_BIT+1) + 9*CLKS_PER_BIT + 1 cycles, ±1 cycle of edge phase. The bench allows ±1.
- rst asserted mid-frame: everything returns to reset values the next edge. The partial frame is lost. If rx is still low after reset, the receiver may start a new frame; this is accepted.
- Sampled bits are always taken at the mid-bit point: HALF_BIT + k*CLKS_PER_BIT cycles after the start edge.

Test Plan (CLKS_PER_BIT=16 unless noted):
- Send 0xA5, stop bit 1, read held 0 -> rxrdy rises once within the latency window; data=0xA5, frame_err=0, overrun=0. Pulse read -> rxrdy=0 next cycle.
- Bytes 0x00, 0xFF, 0x01, 0x80 back-to-back with 1 stop bit, read pulsed on each rxrdy -> four loads with exact values, no overrun. Confirms LSB-first ordering.
- rx low pulse of 5 cycles (shorter than HALF_BIT) -> no rxrdy; state back in IDLE. A following valid 0x3C is received correctly.
- Send 0x55, then 0x66 without reading -> data stays 0x55, overrun=1. A read clears both rxrdy and overrun.
- Send 0x12 with stop bit 0, line held low 40 cycles then released, then send 0x34 -> first load gives data=0x12, frame_err=1; no spurious frame during the low period; second load gives 0x34, frame_err=0.
- Assert rst for 1 cycle during bit 4 of a frame -> all outputs 0 next cycle. Line idle, then send 0x9C -> received correctly. Repeat the 0xA5 case with CLKS_PER_BIT=5208.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: holding-register handshake between the receiver and its consumer
interface uart_rx_if;
    logic       read;
    logic [7:0] data;
    logic       rxrdy;
    logic       frame_err;
    logic       overrun;
    modport master (input read, output data, rxrdy, frame_err, overrun);
    modport slave (output read, input data, rxrdy, frame_err, overrun);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and a ready/read holding register
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    uart_rx_if.master  bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
    localparam logic [12:0] LAST = 13'(CLKS_PER_BIT - 1);
    localparam logic [12:0] HB   = 13'(HALF_BIT);
    state_t      state, nxt;
    logic [1:0]  sync;
    logic [12:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  sh;
    logic        load_p, stop_s, rx_s, tick, run;
    assign rx_s = sync[1];
    assign tick = cnt == LAST;
    assign run  = state inside {START, DATA, STOP};
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = rx_s ? IDLE : START;
            START:   nxt = cnt != HB ? START : rx_s ? IDLE : DATA;
            DATA:    nxt = tick && idx == 3'd7 ? STOP : DATA;
            STOP:    nxt = !tick ? STOP : rx_s ? IDLE : BRK;
            BRK:     nxt = rx_s ? IDLE : BRK;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync          <= 2'b11;
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            sh            <= '0;
            load_p        <= 1'b0;
            stop_s        <= 1'b1;
            bus.data      <= '0;
            bus.rxrdy     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            sync   <= {sync[0], rx};
            state  <= nxt;
            // the counter also restarts after every data sample so each bit gets a full period
            cnt    <= (nxt != state || (state == DATA && tick) || !run) ? '0 : cnt + 13'd1;
            idx    <= state == DATA ? idx + 3'(tick) : '0;
            load_p <= state == STOP && tick;
            if (state == DATA && tick) sh <= {rx_s, sh[7:1]};
            if (state == STOP && tick) stop_s <= rx_s;
            if (load_p && (!bus.rxrdy || bus.read)) begin
                bus.data      <= sh;
                bus.frame_err <= !stop_s;
                bus.rxrdy     <= 1'b1;
                bus.overrun   <= 1'b0;
            end else if (load_p) begin
                bus.overrun   <= 1'b1;
            end else if (bus.read && bus.rxrdy) begin
                bus.rxrdy     <= 1'b0;
                bus.overrun   <= 1'b0;
            end
        end
    end
endmodule
